// File: rtl/pc_branch_unit.sv
// PC register and control-transfer stage fed by the branch comparator.
// Resolves jr/j/br redirects, holds them across stalls, counts branches.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic [31:0]      i_id_pc,
  input  logic             i_br_en,
  input  logic             i_br_cond,
  input  logic [15:0]      i_br_off,
  input  logic             i_j_en,
  input  logic [25:0]      i_j_idx,
  input  logic             i_jr_en,
  input  logic [31:0]      i_jr_tgt,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_plus4,
  output logic             o_flush,
  output logic             o_addr_err,
  output logic             o_pend,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_tk_cnt
);

  typedef enum logic {
    S_RUN,
    S_PEND
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_tgt_q;
  logic             r_addr_err;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_tk_cnt;

  logic [31:0] w_pc4;
  logic [31:0] w_id_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic        w_jr_bad;
  logic        w_sel_br;
  logic        w_run;
  logic        w_take;
  logic [31:0] w_tgt;
  logic        w_br_acc;
  logic        w_br_sat;
  logic        w_tk_sat;

  assign w_pc4    = r_pc + 32'd4;
  assign w_id_pc4 = i_id_pc + 32'd4;
  assign w_br_tgt = w_id_pc4 + {{14{i_br_off[15]}}, i_br_off, 2'b00};
  assign w_j_tgt  = {w_id_pc4[31:28], i_j_idx, 2'b00};
  assign w_jr_bad = i_jr_en && (i_jr_tgt[1:0] != 2'b00);
  assign w_sel_br = i_br_en && !i_j_en && !i_jr_en;
  assign w_run    = (r_state == S_RUN);

  // A misaligned jr still owns the slot, so lower requests stay masked.
  always_comb begin
    w_take = 1'b0;
    w_tgt  = w_pc4;
    priority case (1'b1)
      i_jr_en: begin
        w_take = !w_jr_bad;
        w_tgt  = i_jr_tgt;
      end
      i_j_en: begin
        w_take = 1'b1;
        w_tgt  = w_j_tgt;
      end
      i_br_en: begin
        w_take = i_br_cond;
        w_tgt  = w_br_tgt;
      end
      default: begin
        w_take = 1'b0;
        w_tgt  = w_pc4;
      end
    endcase
  end

  assign w_br_acc = w_run && w_sel_br && (!i_stall || i_br_cond);
  assign w_br_sat = &r_br_cnt;
  assign w_tk_sat = &r_tk_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_tgt_q    <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_run && !i_stall && w_jr_bad;
      case (r_state)
        S_RUN: begin
          if (!i_stall) begin
            r_pc <= w_take ? w_tgt : w_pc4;
          end else if (w_take) begin
            r_tgt_q <= w_tgt;
            r_state <= S_PEND;
          end
        end
        S_PEND: begin
          if (!i_stall) begin
            r_pc    <= r_tgt_q;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt <= '0;
      r_tk_cnt <= '0;
    end else begin
      if (w_br_acc && !w_br_sat) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_br_acc && i_br_cond && !w_tk_sat) begin
        r_tk_cnt <= r_tk_cnt + CNT_W'(1);
      end
    end
  end

  // Flush is combinational so the wrong-path fetch dies in the same cycle.
  assign o_flush    = !rst && !i_stall && (w_run ? w_take : 1'b1);
  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc4;
  assign o_addr_err = r_addr_err;
  assign o_pend     = (r_state == S_PEND);
  assign o_br_cnt   = r_br_cnt;
  assign o_tk_cnt   = r_tk_cnt;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: driver queues expected state,
// a negedge monitor pops and compares.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] id_pc;
  logic        br_en;
  logic        br_cond;
  logic [15:0] br_off;
  logic        j_en;
  logic [25:0] j_idx;
  logic        jr_en;
  logic [31:0] jr_tgt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        addr_err;
  logic        pend;
  logic [15:0] br_cnt;
  logic [15:0] tk_cnt;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        fl;
    logic        ae;
    logic        pd;
    logic [15:0] bc;
    logic [15:0] tc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pc_branch_unit #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_stall   (stall),
    .i_id_pc   (id_pc),
    .i_br_en   (br_en),
    .i_br_cond (br_cond),
    .i_br_off  (br_off),
    .i_j_en    (j_en),
    .i_j_idx   (j_idx),
    .i_jr_en   (jr_en),
    .i_jr_tgt  (jr_tgt),
    .o_pc      (pc),
    .o_pc_plus4(pc_plus4),
    .o_flush   (flush),
    .o_addr_err(addr_err),
    .o_pend    (pend),
    .o_br_cnt  (br_cnt),
    .o_tk_cnt  (tk_cnt)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] e_p4;
      e = exp_q.pop_front();
      e_p4 = e.pc + 32'd4;
      n_vec++;
      if (pc !== e.pc || pc_plus4 !== e_p4 || flush !== e.fl ||
          addr_err !== e.ae || pend !== e.pd ||
          br_cnt !== e.bc || tk_cnt !== e.tc) begin
        n_bad++;
        $display("FAIL %s: got pc=%h p4=%h fl=%b ae=%b pd=%b bc=%h tc=%h exp pc=%h p4=%h fl=%b ae=%b pd=%b bc=%h tc=%h",
                 e.nm, pc, pc_plus4, flush, addr_err, pend, br_cnt, tk_cnt,
                 e.pc, e_p4, e.fl, e.ae, e.pd, e.bc, e.tc);
      end
    end
  end

  task automatic idle_in();
    br_en   = 1'b0;
    br_cond = 1'b0;
    br_off  = 16'h0;
    j_en    = 1'b0;
    j_idx   = 26'h0;
    jr_en   = 1'b0;
    jr_tgt  = 32'h0;
    id_pc   = 32'h0;
  endtask

  task automatic expect_cyc(input string nm, input logic [31:0] e_pc,
                            input logic e_fl, input logic e_ae,
                            input logic e_pd, input logic [15:0] e_bc,
                            input logic [15:0] e_tc);
    exp_t e;
    e.nm = nm;
    e.pc = e_pc;
    e.fl = e_fl;
    e.ae = e_ae;
    e.pd = e_pd;
    e.bc = e_bc;
    e.tc = e_tc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drv_br(input logic [31:0] ipc, input logic c,
                        input logic [15:0] off);
    idle_in();
    id_pc   = ipc;
    br_en   = 1'b1;
    br_cond = c;
    br_off  = off;
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    expect_cyc("idle0", 32'h0, 0, 0, 0, 16'd0, 16'd0);
    expect_cyc("idle1", 32'h4, 0, 0, 0, 16'd0, 16'd0);
    expect_cyc("idle2", 32'h8, 0, 0, 0, 16'd0, 16'd0);
    expect_cyc("idle3", 32'hC, 0, 0, 0, 16'd0, 16'd0);

    drv_br(32'h100, 1'b1, 16'hFFFE);
    expect_cyc("br_tk", 32'h10, 1, 0, 0, 16'd0, 16'd0);
    drv_br(32'h100, 1'b0, 16'hFFFE);
    expect_cyc("br_nt", 32'hFC, 0, 0, 0, 16'd1, 16'd1);

    drv_br(32'h4000_0010, 1'b1, 16'h0010);
    j_en  = 1'b1;
    j_idx = 26'h40;
    expect_cyc("j_over_br", 32'h100, 1, 0, 0, 16'd2, 16'd1);

    idle_in();
    jr_en  = 1'b1;
    jr_tgt = 32'h202;
    expect_cyc("jr_bad", 32'h4000_0100, 0, 0, 0, 16'd2, 16'd1);
    idle_in();
    expect_cyc("aerr_pulse", 32'h4000_0104, 0, 1, 0, 16'd2, 16'd1);
    jr_en  = 1'b1;
    jr_tgt = 32'h200;
    expect_cyc("jr_ok", 32'h4000_0108, 1, 0, 0, 16'd2, 16'd1);

    stall = 1'b1;
    drv_br(32'h7C, 1'b1, 16'h0000);
    expect_cyc("stall_cap", 32'h200, 0, 0, 0, 16'd2, 16'd1);
    idle_in();
    j_en  = 1'b1;
    j_idx = 26'h123;
    expect_cyc("pend1", 32'h200, 0, 0, 1, 16'd3, 16'd2);
    idle_in();
    expect_cyc("pend2", 32'h200, 0, 0, 1, 16'd3, 16'd2);
    expect_cyc("pend3", 32'h200, 0, 0, 1, 16'd3, 16'd2);
    stall = 1'b0;
    drv_br(32'h400, 1'b1, 16'h0040);
    expect_cyc("pend_rel", 32'h200, 1, 0, 1, 16'd3, 16'd2);
    idle_in();
    expect_cyc("redir", 32'h80, 0, 0, 0, 16'd3, 16'd2);

    stall = 1'b1;
    drv_br(32'h7C, 1'b1, 16'h0000);
    expect_cyc("stall_cap2", 32'h84, 0, 0, 0, 16'd3, 16'd2);
    idle_in();
    expect_cyc("pend_b", 32'h84, 0, 0, 1, 16'd4, 16'd3);
    rst = 1'b1;
    expect_cyc("rst_pend", 32'h0, 0, 0, 0, 16'd0, 16'd0);
    rst   = 1'b0;
    stall = 1'b0;
    expect_cyc("post_rst0", 32'h0, 0, 0, 0, 16'd0, 16'd0);
    expect_cyc("post_rst1", 32'h4, 0, 0, 0, 16'd0, 16'd0);

    jr_en  = 1'b1;
    jr_tgt = 32'hFFFF_FFFC;
    expect_cyc("jr_top", 32'h8, 1, 0, 0, 16'd0, 16'd0);
    idle_in();
    expect_cyc("p4_wrap", 32'hFFFF_FFFC, 0, 0, 0, 16'd0, 16'd0);
    expect_cyc("pc_wrap", 32'h0, 0, 0, 0, 16'd0, 16'd0);

    drv_br(32'h0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 65539; i++) begin
      logic [15:0] c;
      c = (i >= 65535) ? 16'hFFFF : 16'(i);
      expect_cyc("sat_run", (i == 0) ? 32'h4 : 32'h0, 1, 0, 0, c, c);
    end
    idle_in();
    expect_cyc("sat_end", 32'h0, 0, 0, 0, 16'hFFFF, 16'hFFFF);

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
Program-counter and control-transfer stage that sits directly downstream of the branch condition comparator. Consumes the comparator's 1-bit take/not-take result together with decoded branch/jump info from ID, computes the target, and updates the PC. Issues a one-cycle IF/ID flush on every redirect. Holds a pending redirect across pipeline stalls, flags misaligned register-jump targets, and keeps saturating branch statistics.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC; no redirect applied while high
id_pc  in  32  PC of the instruction currently in ID
br_en  in  1  ID holds a conditional branch (beq/bne)
br_cond  in  1  comparator output, 1 = take branch
br_off  in  16  branch immediate, signed word offset
j_en  in  1  ID holds j/jal
j_idx  in  26  jump index field
jr_en  in  1  ID holds jr/jalr
jr_tgt  in  32  register jump target (forwarded rs)
pc  out  32  current fetch PC
pc_plus4  out  32  pc + 4 (combinational)
flush  out  1  kill the instruction entering IF/ID this cycle
addr_err  out  1  one-cycle pulse: misaligned jr target
pend  out  1  a redirect is latched and waiting for stall release
br_cnt  out  CNT_W  number of conditional branches resolved
tk_cnt  out  CNT_W  number of taken conditional branches

Behaviour:
- Reset (async, immediate): pc=RESET_PC; state=RUN; pend=0; flush=0; addr_err=0; br_cnt=0; tk_cnt=0.
- Target arithmetic, all modulo 2^32:
  - branch target = id_pc + 4 + (sign-extend(br_off) << 2)
  - jump target = {id_pc+4 [31:28], j_idx, 2'b00}
  - jr target = jr_tgt
- Request priority: jr_en > j_en > br_en. A request is "taken" for jr and j always, and for br only when br_cond=1.
- jr with jr_tgt[1:0] != 0: no redirect, no flush. Register addr_err=1 for exactly one cycle. The request is treated as not-taken.
- States:
  - RUN:
    - stall=0 and taken: pc <= target next edge; flush=1 during that cycle (combinational from the taken request); stay in RUN.
    - stall=0 and not taken: pc <= pc+4.
    - stall=1 and taken: latch target into tgt_q; go to PEND; pc holds.
    - stall=1 and not taken: pc holds.
  - PEND: pend=1; pc holds and all new requests are ignored while stall=1. On the first cycle with stall=0: flush=1, pc <= tgt_q, return to RUN. The ID instruction is not re-evaluated in this cycle.
- Latency: one edge from taken decision to target on pc. Zero branch delay slots; flush removes the wrong-path fetch.
- Counters:
  - br_cnt increments once per conditional branch accepted (br_en=1, no higher-priority request, and either stall=0 in RUN or capture into PEND).
  - tk_cnt increments additionally when that branch is taken.
  - Both saturate at all-ones; no wrap.
- Reset mid-PEND discards tgt_q; pc returns to RESET_PC.
- pc_plus4 wraps 32'hFFFF_FFFC -> 0.

Test Plan:
- Reset release, no requests, stall=0 for 4 cycles -> pc: 0, 4, 8, 12; flush=0 throughout; counters 0.
- id_pc=0x100, br_en=1, br_cond=1, br_off=16'hFFFE -> flush=1 that cycle; pc=0x0FC next cycle; br_cnt=1, tk_cnt=1. Same inputs with br_cond=0 -> pc+4, no flush, br_cnt=2, tk_cnt=1.
- j_en=1 and br_en=1 together, id_pc=0x4000_0010, j_idx=0x40 -> pc=0x4000_0100; br_cnt unchanged.
- jr_en=1, jr_tgt=0x202 -> addr_err pulse for 1 cycle, no flush, pc advances by 4. jr_tgt=0x200 -> pc=0x200, flush=1.
- stall=1 while branch taken to 0x80, stall held 3 cycles -> pend=1 and pc frozen for 3 cycles; cycle stall falls: flush=1, pc=0x80 next; assert rst during PEND in a repeat run -> pc=RESET_PC, pend=0 immediately.
- Force 2^CNT_W+3 taken branches -> br_cnt and tk_cnt stuck at 16'hFFFF.
